// File: rtl/qif_neuron_array.sv
// qif_neuron_array
// ----------------
// Time-multiplexed array of N_CH quadratic integrate-and-fire neurons that
// share a single update datapath. One request on `step` walks through every
// channel, one channel per clock, applying
//   V <- sat(V + I/2^I_SHIFT + (V/2^A_SHIFT)^2)
// with threshold/reset, a per-channel refractory period and overrun detection.
// The synapse accumulator upstream drives I_syn and step; the spike router
// downstream consumes spike when done pulses.
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   step     request one update of all channels (sampled every clk)
//   I_syn    packed signed input currents, channel c at [c*WIDTH +: WIDTH]
//   clr_ovr  clears the sticky overrun flag
//   V_mem    packed signed membrane voltages, same packing as I_syn
//   spike    per-channel spike flags of the most recent step
//   busy     high while a step is being processed
//   done     one-cycle pulse when the last channel has been updated
//   overrun  sticky: a step request arrived while busy
module qif_neuron_array #(
  parameter int WIDTH   = 8,
  parameter int N_CH    = 4,
  parameter int V_TH    = 50,
  parameter int V_RESET = -20,
  parameter int I_SHIFT = 2,
  parameter int A_SHIFT = 3,
  parameter int REFRAC  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step,
  input  logic [N_CH*WIDTH-1:0] I_syn,
  input  logic                  clr_ovr,
  output logic [N_CH*WIDTH-1:0] V_mem,
  output logic [N_CH-1:0]       spike,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  // Internal arithmetic width: wide enough that V + I/2^k + q^2 never wraps
  // before saturation.
  localparam int EW = 2*WIDTH + 2;
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic signed [WIDTH-1:0] V_TH_W    = WIDTH'(V_TH);
  localparam logic signed [WIDTH-1:0] V_RESET_W = WIDTH'(V_RESET);
  localparam logic [RW-1:0]           REFRAC_W  = RW'(REFRAC);
  localparam logic [IW-1:0]           LAST_CH   = IW'(N_CH - 1);

  // Biases added to negative operands so the arithmetic shift truncates
  // toward zero like a signed division would.
  localparam logic signed [EW-1:0] I_BIAS  = EW'((1 << I_SHIFT) - 1);
  localparam logic signed [EW-1:0] A_BIAS  = EW'((1 << A_SHIFT) - 1);
  localparam logic signed [EW-1:0] SAT_MAX = EW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = EW'(-(1 << (WIDTH - 1)));

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t state, state_next;

  logic [IW-1:0]           idx;
  logic signed [WIDTH-1:0] v_reg  [N_CH];
  logic signed [WIDTH-1:0] i_snap [N_CH];
  logic [RW-1:0]           r_reg  [N_CH];

  logic accept;
  logic ovr_event;
  logic last_upd;

  logic signed [WIDTH-1:0] cur_v;
  logic signed [WIDTH-1:0] cur_i;
  logic [RW-1:0]           cur_r;
  logic signed [EW-1:0]    v_ext;
  logic signed [EW-1:0]    i_ext;
  logic signed [EW-1:0]    i_adj;
  logic signed [EW-1:0]    i_term;
  logic signed [EW-1:0]    a_adj;
  logic signed [EW-1:0]    q_term;
  logic signed [EW-1:0]    q_sq;
  logic signed [EW-1:0]    sum;
  logic signed [WIDTH-1:0] v_sat;
  logic signed [WIDTH-1:0] v_next;
  logic [RW-1:0]           r_next;
  logic                    fire;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic: a step starts the sweep, the last channel ends it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (step) state_next = UPDATE;
      UPDATE:  if (idx == LAST_CH) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs. A step seen during UPDATE is dropped and flagged as overrun.
  always_comb begin
    busy      = (state == UPDATE);
    accept    = (state == IDLE) && step;
    ovr_event = (state == UPDATE) && step;
    last_upd  = (state == UPDATE) && (idx == LAST_CH);
  end

  // Shared neuron datapath for the channel selected by idx.
  always_comb begin
    cur_v  = v_reg[idx];
    cur_i  = i_snap[idx];
    cur_r  = r_reg[idx];

    v_ext  = {{(EW-WIDTH){cur_v[WIDTH-1]}}, cur_v};
    i_ext  = {{(EW-WIDTH){cur_i[WIDTH-1]}}, cur_i};

    i_adj  = i_ext[EW-1] ? (i_ext + I_BIAS) : i_ext;
    i_term = i_adj >>> I_SHIFT;
    a_adj  = v_ext[EW-1] ? (v_ext + A_BIAS) : v_ext;
    q_term = a_adj >>> A_SHIFT;

    // |q| < 2^(WIDTH-1), so the square fits comfortably in EW bits.
    q_sq   = q_term * q_term;
    sum    = v_ext + i_term + q_sq;

    if (sum > SAT_MAX) begin
      v_sat = SAT_MAX[WIDTH-1:0];
    end else if (sum < SAT_MIN) begin
      v_sat = SAT_MIN[WIDTH-1:0];
    end else begin
      v_sat = sum[WIDTH-1:0];
    end

    // Refractory hold beats threshold, which beats integration; the threshold
    // test looks at the membrane value from before this update.
    v_next = v_sat;
    r_next = cur_r;
    fire   = 1'b0;
    if (cur_r != '0) begin
      v_next = V_RESET_W;
      r_next = cur_r - RW'(1);
    end else if (cur_v >= V_TH_W) begin
      v_next = V_RESET_W;
      r_next = REFRAC_W;
      fire   = 1'b1;
    end
  end

  // Channel state: currents are frozen at acceptance so later I_syn changes
  // cannot leak into the sweep; only the indexed channel is written per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        v_reg[c]  <= '0;
        i_snap[c] <= '0;
        r_reg[c]  <= '0;
      end
      spike <= '0;
      idx   <= '0;
    end else if (accept) begin
      for (int c = 0; c < N_CH; c++) begin
        i_snap[c] <= I_syn[c*WIDTH +: WIDTH];
      end
      spike <= '0;
      idx   <= '0;
    end else if (state == UPDATE) begin
      v_reg[idx] <= v_next;
      r_reg[idx] <= r_next;
      if (fire) begin
        spike[idx] <= 1'b1;
      end
      idx <= last_upd ? '0 : idx + IW'(1);
    end
  end

  // Completion pulse and sticky overrun; a new overrun event beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= last_upd;
      overrun <= ovr_event | (overrun & ~clr_ovr);
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_pack
    assign V_mem[c*WIDTH +: WIDTH] = v_reg[c];
  end

endmodule
